// File: rtl/multi_pulse_seq.sv
// Multi-channel periodic pulse sequencer: one shared cycle counter drives a sync
// pulse and NCH programmable channel windows, with shadowed configuration.
module multi_pulse_seq #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 32
) (
  input  logic              clk_pll,
  input  logic              reset,
  input  logic [CW-1:0]     period,
  input  logic [CW-1:0]     sync_up,
  input  logic [NCH*CW-1:0] ch_start,
  input  logic [NCH*CW-1:0] ch_width,
  input  logic [NCH-1:0]    ch_alt,
  input  logic [15:0]       n_per,
  input  logic              cfg_load,
  input  logic              start,
  input  logic              stop,
  output logic [NCH-1:0]    ch_out,
  output logic              sync_on,
  output logic              busy,
  output logic              done,
  output logic [15:0]       per_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [CW-1:0]     period;
    logic [CW-1:0]     sync_up;
    logic [NCH*CW-1:0] ch_start;
    logic [NCH*CW-1:0] ch_width;
    logic [NCH-1:0]    ch_alt;
    logic [15:0]       n_per;
  } cfg_t;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    per_cnt_q, per_cnt_d;
  cfg_t           sh_q, sh_d, act_q, act_d, cfg_in;
  logic [NCH-1:0] ch_out_q, ch_out_d, ch_win;
  logic           sync_on_q, sync_on_d, sync_win;
  logic           busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]  eff_period;
  logic           wrap, last_per;

  // Window decode from the active set; cnt never exceeds the period, so windows clamp there.
  always_comb begin
    cfg_in.period   = period;
    cfg_in.sync_up  = sync_up;
    cfg_in.ch_start = ch_start;
    cfg_in.ch_width = ch_width;
    cfg_in.ch_alt   = ch_alt;
    cfg_in.n_per    = n_per;

    eff_period = (act_q.period < CW'(2)) ? CW'(2) : act_q.period;
    wrap       = (state_q != IDLE) && (cnt_q == eff_period - CW'(1));
    last_per   = (act_q.n_per != 16'd0) && ((per_cnt_q + 16'd1) == act_q.n_per);
    sync_win   = (cnt_q < act_q.sync_up);

    ch_win = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_win[i] = (cnt_q >= act_q.ch_start[i*CW +: CW]) &&
                  ({1'b0, cnt_q} < ({1'b0, act_q.ch_start[i*CW +: CW]} +
                                    {1'b0, act_q.ch_width[i*CW +: CW]})) &&
                  !(act_q.ch_alt[i] && per_cnt_q[0]);
    end
  end

  // Next-state, counters and shadow/active configuration handover.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_cnt_d = per_cnt_q;
    sh_d      = cfg_load ? cfg_in : sh_q;
    act_d     = act_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        act_d = sh_d;
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          per_cnt_d = '0;
        end
      end
      RUN, DRAIN: begin
        if (state_q == RUN && stop) state_d = DRAIN;
        if (wrap) begin
          cnt_d     = '0;
          per_cnt_d = per_cnt_q + 16'd1;
          act_d     = sh_d;
          if (last_per || state_q == DRAIN || stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    ch_out_d  = (state_q != IDLE && state_d != IDLE) ? ch_win : '0;
    sync_on_d = (state_q != IDLE && state_d != IDLE) && sync_win;
  end

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_cnt_q <= '0;
      sh_q      <= '0;
      act_q     <= '0;
      ch_out_q  <= '0;
      sync_on_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_cnt_q <= per_cnt_d;
      sh_q      <= sh_d;
      act_q     <= act_d;
      ch_out_q  <= ch_out_d;
      sync_on_q <= sync_on_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ch_out  = ch_out_q;
  assign sync_on = sync_on_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign per_cnt = per_cnt_q;

endmodule

// File: doc/multi_pulse_seq.md
MULTI_PULSE_SEQ -- requirements
Module: multi_pulse_seq

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent pulse channels (1..16).
REQ-002 SHALL have parameter CW, default 32, width of all timing words in clk_pll cycles.
REQ-003 SHALL have port clk_pll  input  1  the single clock; all logic is rising-edge clocked on it.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port period  input  CW  sequence period in cycles.
REQ-006 SHALL have port sync_up  input  CW  sync pulse width in cycles.
REQ-007 SHALL have port ch_start  input  NCH*CW  per-channel start offset; channel i occupies bits [i*CW +: CW].
REQ-008 SHALL have port ch_width  input  NCH*CW  per-channel pulse width; same packing.
REQ-009 SHALL have port ch_alt  input  NCH  per-channel alternate-period blanking enable.
REQ-010 SHALL have port n_per  input  16  number of periods to run; 0 means free-run.
REQ-011 SHALL have port cfg_load  input  1  one-cycle strobe that captures period..n_per into shadow registers.
REQ-012 SHALL have port start  input  1  one-cycle run request.
REQ-013 SHALL have port stop  input  1  one-cycle graceful stop request.
REQ-014 SHALL have port ch_out  output  NCH  registered channel pulses.
REQ-015 SHALL have port sync_on  output  1  registered sync pulse.
REQ-016 SHALL have port busy  output  1  high while not IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse on return to IDLE.
REQ-018 SHALL have port per_cnt  output  16  number of completed periods in the current run.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN; DRAIN = finish the current period, then IDLE.
REQ-020 SHALL capture all configuration inputs into a shadow set on cfg_load, in any state.
REQ-021 SHALL copy shadow to the active set immediately in IDLE, and otherwise only at the cycle where the cycle counter wraps; a period never mixes old and new settings.
REQ-022 SHALL use effective period = max(active period, 2).
REQ-023 IDLE + start: SHALL enter RUN with cycle counter cnt=0, per_cnt=0 on the next cycle.
REQ-024 RUN: cnt SHALL increment each cycle and wrap to 0 after effective period-1; per_cnt SHALL increment on each wrap.
REQ-025 When n_per!=0 and the wrap completes period n_per, SHALL go to IDLE; per_cnt SHALL then equal n_per.
REQ-026 RUN + stop: SHALL enter DRAIN; stop in IDLE or DRAIN SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-027 Simultaneous start and stop in IDLE: start SHALL win; stop is dropped.
REQ-028 Channel i window SHALL be true when ch_start_i <= cnt < ch_start_i + ch_width_i, with the sum computed in CW+1 bits; the window never extends past the period end (no wrap into the next period).
REQ-029 ch_width_i=0 or ch_start_i >= effective period: channel i SHALL stay low.
REQ-030 ch_alt_i=1: channel i SHALL be forced low when per_cnt is odd.
REQ-031 sync_on window SHALL be cnt < sync_up, with the same width and clamping rules.
REQ-032 ch_out and sync_on SHALL be registered: high in cycle k+1 when the window is true for cnt in cycle k; low in IDLE.
REQ-033 done SHALL pulse exactly one cycle, coincident with the first IDLE cycle; busy SHALL drop in the same cycle.
REQ-034 per_cnt SHALL hold its final value in IDLE until the next start.

Reset
REQ-035 reset SHALL force IDLE; ch_out, sync_on, busy, done = 0; per_cnt, cnt = 0; shadow and active sets = 0.
REQ-036 reset mid-run SHALL take effect on the next edge with no completing pulse and no done pulse.

Verification
REQ-037 Setup: period=10, sync_up=2, ch0 start=3 width=4, n_per=2, load then start. Expect: sync_on high at cnt 0-1 (one-cycle latency); ch_out[0] high at cnt 3-6 in both periods; done at cycle 21 after start; per_cnt=2.
REQ-038 Setup: ch1 start=8 width=5, period=10. Expect: ch_out[1] high at cnt 8-9 only; nothing at the start of the next period.
REQ-039 Setup: n_per=0, ch_alt[0]=1. Expect: ch0 pulses in periods 0, 2 and 4 only. Then stop at cnt=4. Expect: the period finishes and done asserts after cnt 9.
REQ-040 Setup: during a run with period=10, cfg_load with period=6 at cnt=5. Expect: the current period stays at 10 cycles and the next period is 6 cycles.
REQ-041 Setup: period=0 or 1. Expect: a 2-cycle period. Setup: reset asserted at cnt=5 of a run. Expect: all outputs 0 and busy=0 next cycle, with no done pulse.
